// File: rtl/img_pkg.sv
// Shared image-pipeline types and default frame geometry for the Sobel front end.
package img_pkg;

   localparam int PIX_W      = 12;
   localparam int DEF_WIDTH  = 640;
   localparam int DEF_HEIGHT = 480;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      FILL0  = 2'd0,
      FILL1  = 2'd1,
      STREAM = 2'd2
   } lb_state_t;

endpackage

// File: rtl/line_ram.sv
// One image line of pixel storage: synchronous write, and the read port shows the
// pre-write content of the addressed word so old data can be moved in the same cycle.
module line_ram
   import img_pkg::*;
#(
   parameter int DEPTH = DEF_WIDTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  pixel_t        wdata_i,
   output pixel_t        rdata_o
);

   pixel_t mem_q [DEPTH];

   // Pixel storage; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_line_buffer.sv
// Line buffer feeding the 3x3 Sobel stage: keeps the two previous lines and emits a
// registered column triple with valid, border and end-of-frame flags.
module conv_line_buffer
   import img_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             sof,
   output logic [PIX_W-1:0] row0_pixel,
   output logic [PIX_W-1:0] row1_pixel,
   output logic [PIX_W-1:0] row2_pixel,
   output logic             row1_pixel_edge,
   output logic             out_valid,
   output logic             frame_done
);

   localparam int COL_W = $clog2(WIDTH);
   localparam int ROW_W = $clog2(HEIGHT);
   localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

   logic [COL_W-1:0] col_q;
   logic [COL_W-1:0] col_s;
   logic [ROW_W-1:0] row_q;
   logic [ROW_W-1:0] row_s;
   lb_state_t        state_q;
   lb_state_t        state_s;

   pixel_t line_a_s;
   pixel_t line_b_s;

   pixel_t row0_q;
   pixel_t row1_q;
   pixel_t row2_q;
   logic   border_q;
   logic   valid_q;
   logic   done_q;

   // Position of the incoming pixel; an accepted sof restarts the frame at (0,0).
   always_comb begin
      col_s   = col_q;
      row_s   = row_q;
      state_s = state_q;
      if (in_valid && sof) begin
         col_s   = COL_ZERO;
         row_s   = ROW_ZERO;
         state_s = FILL0;
      end else begin
         col_s   = col_q;
         row_s   = row_q;
         state_s = state_q;
      end
   end

   line_ram #(.DEPTH(WIDTH), .AW(COL_W)) u_line_a (
      .clk     (clk),
      .we_i    (in_valid),
      .addr_i  (col_s),
      .wdata_i (in_pixel),
      .rdata_o (line_a_s)
   );

   line_ram #(.DEPTH(WIDTH), .AW(COL_W)) u_line_b (
      .clk     (clk),
      .we_i    (in_valid),
      .addr_i  (col_s),
      .wdata_i (line_a_s),
      .rdata_o (line_b_s)
   );

   // Raster counters, fill/stream FSM and the registered output triple.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q    <= COL_ZERO;
         row_q    <= ROW_ZERO;
         state_q  <= FILL0;
         row0_q   <= PIX_W'(0);
         row1_q   <= PIX_W'(0);
         row2_q   <= PIX_W'(0);
         border_q <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else if (in_valid) begin
         row2_q   <= in_pixel;
         row1_q   <= line_a_s;
         row0_q   <= line_b_s;
         border_q <= (col_s == COL_ZERO) || (col_s == COL_LAST);
         valid_q  <= (state_s == STREAM);
         done_q   <= (col_s == COL_LAST) && (row_s == ROW_LAST);
         if (col_s == COL_LAST) begin
            col_q <= COL_ZERO;
            if (row_s == ROW_LAST) begin
               row_q   <= ROW_ZERO;
               state_q <= FILL0;
            end else begin
               row_q <= row_s + ROW_W'(1);
               case (state_s)
                  FILL0:   state_q <= FILL1;
                  FILL1:   state_q <= STREAM;
                  default: state_q <= STREAM;
               endcase
            end
         end else begin
            col_q   <= col_s + COL_W'(1);
            row_q   <= row_s;
            state_q <= state_s;
         end
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end
   end

   assign row0_pixel      = row0_q;
   assign row1_pixel      = row1_q;
   assign row2_pixel      = row2_q;
   assign row1_pixel_edge = border_q;
   assign out_valid       = valid_q;
   assign frame_done      = done_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Bench for conv_line_buffer: a 4x4 instance for directed scenarios and a 640-wide
// instance for random streaming, both checked against a frame-image reference model.
module tb_conv_line_buffer;
   import img_pkg::*;

   localparam int SW = 4;
   localparam int SH = 4;
   localparam int LW = 640;
   localparam int LH = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic             s_valid, s_sof, s_border, s_ov, s_done;
   logic [PIX_W-1:0] s_pix, s_r0, s_r1, s_r2;
   logic             l_valid, l_sof, l_border, l_ov, l_done;
   logic [PIX_W-1:0] l_pix, l_r0, l_r1, l_r2;

   conv_line_buffer #(.WIDTH(SW), .HEIGHT(SH)) dut_s (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_pixel(s_pix), .sof(s_sof),
      .row0_pixel(s_r0), .row1_pixel(s_r1), .row2_pixel(s_r2),
      .row1_pixel_edge(s_border), .out_valid(s_ov), .frame_done(s_done)
   );

   conv_line_buffer #(.WIDTH(LW), .HEIGHT(LH)) dut_l (
      .clk(clk), .rst(rst), .in_valid(l_valid), .in_pixel(l_pix), .sof(l_sof),
      .row0_pixel(l_r0), .row1_pixel(l_r1), .row2_pixel(l_r2),
      .row1_pixel_edge(l_border), .out_valid(l_ov), .frame_done(l_done)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: the current frame as an image, indexed [dut][row][col].
   int               img [2][LH][LW];
   int               mr [2];
   int               mc [2];
   logic [PIX_W-1:0] e0 [2];
   logic [PIX_W-1:0] e1 [2];
   logic [PIX_W-1:0] e2 [2];
   logic             ev [2];
   logic             eborder [2];
   logic             edone [2];
   logic             eknown [2];

   logic [3*PIX_W+2:0] got_v, exp_v;

   task automatic model_reset(input int k);
      mr[k] = 0; mc[k] = 0;
      e0[k] = '0; e1[k] = '0; e2[k] = '0;
      ev[k] = 1'b0; eborder[k] = 1'b0; edone[k] = 1'b0; eknown[k] = 1'b1;
   endtask

   task automatic model_step(input int k, input int w, input int h,
                             input logic v, input logic [PIX_W-1:0] p, input logic s);
      if (v) begin
         if (s) begin
            mr[k] = 0; mc[k] = 0;
         end
         img[k][mr[k]][mc[k]] = int'(p);
         ev[k]     = (mr[k] >= 2);
         eknown[k] = ev[k];
         if (ev[k]) begin
            e0[k] = PIX_W'(img[k][mr[k]-2][mc[k]]);
            e1[k] = PIX_W'(img[k][mr[k]-1][mc[k]]);
         end
         e2[k]      = p;
         eborder[k] = (mc[k] == 0) || (mc[k] == w - 1);
         edone[k]   = (mr[k] == h - 1) && (mc[k] == w - 1);
         mc[k]++;
         if (mc[k] == w) begin
            mc[k] = 0;
            mr[k]++;
            if (mr[k] == h) mr[k] = 0;
         end
      end else begin
         ev[k]    = 1'b0;
         edone[k] = 1'b0;
      end
   endtask

   task automatic drive_s(input logic v, input logic [PIX_W-1:0] p, input logic s);
      s_valid = v; s_pix = p; s_sof = s;
      model_step(0, SW, SH, v, p, s);
      @(posedge clk);
      #1;
   endtask

   task automatic drive_l(input logic v, input logic [PIX_W-1:0] p, input logic s);
      l_valid = v; l_pix = p; l_sof = s;
      model_step(1, LW, LH, v, p, s);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_valid = 1'b0; s_pix = '0; s_sof = 1'b0;
      l_valid = 1'b0; l_pix = '0; l_sof = 1'b0;
      #2 rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      got_v = {s_ov, s_done, s_border, s_r2, s_r0, s_r1};
      checks++;
      if (got_v !== '0) begin
         errors++; $display("FAIL reset_small got %h expected 0", got_v);
      end
      got_v = {l_ov, l_done, l_border, l_r2, l_r0, l_r1};
      checks++;
      if (got_v !== '0) begin
         errors++; $display("FAIL reset_large got %h expected 0", got_v);
      end
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
   endtask

   task automatic test_basic_fill();
      for (int i = 0; i < SW * SH + 1; i++) begin
         if (i < SW * SH) drive_s(1'b1, PIX_W'(i), i == 0);
         else             drive_s(1'b0, PIX_W'(0), 1'b0);
         got_v = {s_ov, s_done, s_border, s_r2, eknown[0] ? {s_r0, s_r1} : 24'h0};
         exp_v = {ev[0], edone[0], eborder[0], e2[0], eknown[0] ? {e0[0], e1[0]} : 24'h0};
         checks++;
         if (got_v !== exp_v) begin
            errors++; $display("FAIL basic_fill step %0d got %h expected %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 2 * SW * SH; i++) begin
         if (i % 2 == 0) drive_s(1'b1, PIX_W'(i / 2), i == 0);
         else            drive_s(1'b0, PIX_W'(12'hABC), 1'b0);
         got_v = {s_ov, s_done, s_border, s_r2, eknown[0] ? {s_r0, s_r1} : 24'h0};
         exp_v = {ev[0], edone[0], eborder[0], e2[0], eknown[0] ? {e0[0], e1[0]} : 24'h0};
         checks++;
         if (got_v !== exp_v) begin
            errors++; $display("FAIL gaps step %0d got %h expected %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2 * SW * SH + 4; i++) begin
         drive_s(1'b1, PIX_W'(i), (i == 0) || (i == SW * SH));
         got_v = {s_ov, s_done, s_border, s_r2, eknown[0] ? {s_r0, s_r1} : 24'h0};
         exp_v = {ev[0], edone[0], eborder[0], e2[0], eknown[0] ? {e0[0], e1[0]} : 24'h0};
         checks++;
         if (got_v !== exp_v) begin
            errors++; $display("FAIL back_to_back step %0d got %h expected %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_sof_abort();
      for (int i = 0; i < 9 + 1 + 16; i++) begin
         drive_s(1'b1, PIX_W'($urandom), (i == 0) || (i == 9));
         got_v = {s_ov, s_done, s_border, s_r2, eknown[0] ? {s_r0, s_r1} : 24'h0};
         exp_v = {ev[0], edone[0], eborder[0], e2[0], eknown[0] ? {e0[0], e1[0]} : 24'h0};
         checks++;
         if (got_v !== exp_v) begin
            errors++; $display("FAIL sof_abort step %0d got %h expected %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      for (int i = 0; i < 10; i++) begin
         drive_s(1'b1, PIX_W'(i + 200), i == 0);
      end
      s_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      got_v = {s_ov, s_done, s_border, s_r2, s_r0, s_r1};
      checks++;
      if (got_v !== '0) begin
         errors++; $display("FAIL mid_reset_async got %h expected 0", got_v);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset(0);
      model_reset(1);
      for (int i = 0; i < SW * SH + 1; i++) begin
         if (i < SW * SH) drive_s(1'b1, PIX_W'(i), 1'b0);
         else             drive_s(1'b0, PIX_W'(0), 1'b0);
         got_v = {s_ov, s_done, s_border, s_r2, eknown[0] ? {s_r0, s_r1} : 24'h0};
         exp_v = {ev[0], edone[0], eborder[0], e2[0], eknown[0] ? {e0[0], e1[0]} : 24'h0};
         checks++;
         if (got_v !== exp_v) begin
            errors++; $display("FAIL mid_reset_refill step %0d got %h expected %h", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_default_size();
      int   acc = 0;
      int   vcount = 0;
      int   ecount = 0;
      int   frames = 0;
      logic v;
      while (acc < 2 * LW * LH) begin
         v = ($urandom_range(0, 7) != 0);
         drive_l(v, PIX_W'($urandom), v && (acc == 0));
         if (v) acc++;
         got_v = {l_ov, l_done, l_border, l_r2, eknown[1] ? {l_r0, l_r1} : 24'h0};
         exp_v = {ev[1], edone[1], eborder[1], e2[1], eknown[1] ? {e0[1], e1[1]} : 24'h0};
         checks++;
         if (got_v !== exp_v) begin
            errors++; $display("FAIL large_stream pixel %0d got %h expected %h", acc, got_v, exp_v);
         end
         if (l_ov) vcount++;
         if (l_ov && l_border) ecount++;
         if (l_done) begin
            frames++;
            checks++;
            if (vcount != (LH - 2) * LW) begin
               errors++; $display("FAIL large_valid_count frame %0d got %0d expected %0d", frames, vcount, (LH - 2) * LW);
            end
            checks++;
            if (ecount != 2 * (LH - 2)) begin
               errors++; $display("FAIL large_edge_count frame %0d got %0d expected %0d", frames, ecount, 2 * (LH - 2));
            end
            vcount = 0;
            ecount = 0;
         end
      end
      checks++;
      if (frames != 2) begin
         errors++; $display("FAIL large_frame_count got %0d expected 2", frames);
      end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_gaps();
      test_back_to_back();
      test_sof_abort();
      test_reset_mid_stream();
      test_default_size();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
